// File: rtl/abru_bus_pkg.sv
// ABruTECH bus controller shared definitions.
// State encodings, master/slave counts and grant helpers.
package abru_bus_pkg;

    localparam int NUM_MASTERS = 12;
    localparam int NUM_SLAVES  = 6;

    localparam logic [3:0] NO_MASTER = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_GRANT   = 4'd1,
        ST_ACTIVE  = 4'd2,
        ST_RELEASE = 4'd3
    } bus_state_e;

    // One-hot grant vector for a master index; zero for NO_MASTER.
    function automatic logic [NUM_MASTERS-1:0] onehot_grant(
        input logic [3:0] idx
    );
        logic [NUM_MASTERS-1:0] g;
        g = '0;
        if (32'(idx) < NUM_MASTERS) begin
            g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Index following idx, wrapping after the last master.
    function automatic logic [3:0] next_index(input logic [3:0] idx);
        logic [3:0] n;
        if (32'(idx) >= NUM_MASTERS - 1) begin
            n = 4'd0;
        end else begin
            n = idx + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/abru_bus_prio_enc.sv
// Rotating-start priority encoder for master requests.
// The first requester at or after start (wrapping) wins.
module abru_bus_prio_enc
    import abru_bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [3:0]             start,
    output logic                   valid,
    output logic [3:0]             idx
);

    logic [4:0] base;
    logic [4:0] cand;

    // Scan all masters once, starting from the requested position.
    always_comb begin
        valid = 1'b0;
        idx   = NO_MASTER;
        cand  = 5'd0;
        base  = (32'(start) < NUM_MASTERS) ? {1'b0, start} : 5'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = base + 5'(i);
            if (32'(cand) >= NUM_MASTERS) begin
                cand = cand - 5'(NUM_MASTERS);
            end
            if (!valid && req[cand[3:0]]) begin
                valid = 1'b1;
                idx   = cand[3:0];
            end
        end
    end

endmodule

// File: rtl/abru_bus_controller.sv
// ABruTECH serial bus arbiter: one-hot grant, ownership tracking.
// Define BUS_ROUND_ROBIN_EN for rotating instead of fixed priority.
module abru_bus_controller
    import abru_bus_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_reqs,
    output logic [NUM_MASTERS-1:0] m_grants,
    input  logic [NUM_SLAVES-1:0]  slaves,
    input  logic                   bus_util,
    output logic [3:0]             state,
    output logic [3:0]             mid_current
);

    bus_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grants_q, grants_d;
    logic [3:0]             mid_q, mid_d;
    logic [7:0]             cnt_q, cnt_d;

    logic       enc_valid;
    logic [3:0] enc_idx;
    logic [3:0] enc_start;
    logic       grant_fire;
    logic       owner_req;
    logic       timed_out;

    abru_bus_prio_enc u_prio_enc (
        .req   (m_reqs),
        .start (enc_start),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    assign grant_fire = (state_q == ST_IDLE) && enc_valid &&
                        (slaves == '0) && !bus_util;
    assign owner_req  = |(m_reqs & grants_q);
    assign timed_out  = (cnt_q == 8'(GRANT_TIMEOUT - 1));

`ifdef BUS_ROUND_ROBIN_EN
    logic [3:0] rr_q, rr_d;

    assign enc_start = rr_q;

    // Search origin moves past each newly granted master.
    always_comb begin
        rr_d = rr_q;
        if (grant_fire) begin
            rr_d = next_index(enc_idx);
        end
    end

    // Rotation pointer register; search restarts at 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 4'd0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign enc_start = 4'd0;
`endif

    // Next-state and registered-output logic for the ownership FSM.
    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        mid_d    = mid_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                grants_d = '0;
                mid_d    = NO_MASTER;
                if (grant_fire) begin
                    state_d  = ST_GRANT;
                    grants_d = onehot_grant(enc_idx);
                    mid_d    = enc_idx;
                    cnt_d    = 8'd0;
                end
            end
            ST_GRANT: begin
                if (bus_util) begin
                    state_d = ST_ACTIVE;
                end else if (!owner_req || timed_out) begin
                    state_d  = ST_RELEASE;
                    grants_d = '0;
                    mid_d    = NO_MASTER;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (!owner_req && !bus_util) begin
                    state_d  = ST_RELEASE;
                    grants_d = '0;
                    mid_d    = NO_MASTER;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                grants_d = '0;
                mid_d    = NO_MASTER;
            end
            default: begin
                state_d  = ST_IDLE;
                grants_d = '0;
                mid_d    = NO_MASTER;
                cnt_d    = 8'd0;
            end
        endcase
    end

    // FSM state, grant, owner index and timeout counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grants_q <= '0;
            mid_q    <= NO_MASTER;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            mid_q    <= mid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_grants    = grants_q;
    assign mid_current = mid_q;
    assign state       = state_q;

endmodule

// File: tb/tb_abru_bus_controller.sv
// Self-checking bench for abru_bus_controller.
// Expected grant winners are queued and popped as grants appear.
module tb_abru_bus_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] m_reqs;
    logic [11:0] m_grants;
    logic [5:0]  slaves;
    logic        bus_util;
    logic [3:0]  state;
    logic [3:0]  mid_current;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    abru_bus_controller #(.GRANT_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_reqs      (m_reqs),
        .m_grants    (m_grants),
        .slaves      (slaves),
        .bus_util    (bus_util),
        .state       (state),
        .mid_current (mid_current)
    );

    function automatic logic [11:0] oh(input int i);
        logic [11:0] v;
        v = 12'd1;
        return v << i;
    endfunction

    task automatic test_reset();
        rst = 1'b1; m_reqs = 12'h020; slaves = '0; bus_util = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (m_grants !== 12'h000) begin
                bad++; $display("FAIL rst_grants got=%h want=000", m_grants);
            end
            total++;
            if (state !== 4'd0) begin
                bad++; $display("FAIL rst_state got=%0d want=0", state);
            end
            total++;
            if (mid_current !== 4'hF) begin
                bad++; $display("FAIL rst_mid got=%h want=f", mid_current);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int e;
        exp_q.push_back(5);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (state !== 4'd1) begin
            bad++; $display("FAIL single_state got=%0d want=1", state);
        end
        total++;
        if (mid_current !== 4'(e)) begin
            bad++; $display("FAIL single_mid got=%0d want=%0d", mid_current, e);
        end
        total++;
        if (m_grants !== oh(e)) begin
            bad++; $display("FAIL single_grant got=%h want=%h", m_grants, oh(e));
        end
        bus_util = 1'b1;
        @(negedge clk);
        total++;
        if (state !== 4'd2 || m_grants !== 12'h020) begin
            bad++; $display("FAIL single_active st=%0d g=%h want 2/020", state, m_grants);
        end
        m_reqs = '0; bus_util = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 4'd3 || m_grants !== 12'h000 || mid_current !== 4'hF) begin
            bad++;
            $display("FAIL single_release st=%0d g=%h mid=%h want 3/000/f",
                     state, m_grants, mid_current);
        end
        @(negedge clk);
        total++;
        if (state !== 4'd0) begin
            bad++; $display("FAIL single_idle got=%0d want=0", state);
        end
    endtask

    task automatic test_contention();
        int  e;
        bit  found;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(7);
        m_reqs = 12'h0A4;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (state == 4'd1) found = 1'b1;
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL cont_wait k=%0d got=nogrant want=%0d", k, e);
            end else if (mid_current !== 4'(e) || m_grants !== oh(e)) begin
                bad++;
                $display("FAIL cont_grant k=%0d mid=%0d g=%h want %0d/%h",
                         k, mid_current, m_grants, e, oh(e));
            end
            total++;
            if ($countones(m_grants) != 1) begin
                bad++; $display("FAIL cont_onehot got=%h want=onehot", m_grants);
            end
            m_reqs[e] = 1'b0;
        end
        repeat (2) @(negedge clk);
        total++;
        if (state !== 4'd0 || m_grants !== 12'h000) begin
            bad++; $display("FAIL cont_idle st=%0d g=%h want 0/000", state, m_grants);
        end
    endtask

    task automatic test_timeout();
        int e;
        bit found;
        exp_q.push_back(0);
        m_reqs = 12'h001; bus_util = 1'b0;
        e = exp_q.pop_front();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (state == 4'd1) found = 1'b1;
        end
        total++;
        if (!found || mid_current !== 4'(e)) begin
            bad++; $display("FAIL to_grant mid=%h want=%0d", mid_current, e);
        end
        repeat (15) @(negedge clk);
        total++;
        if (state !== 4'd1 || m_grants !== 12'h001) begin
            bad++; $display("FAIL to_early st=%0d g=%h want 1/001", state, m_grants);
        end
        @(negedge clk);
        total++;
        if (state !== 4'd3 || m_grants !== 12'h000) begin
            bad++; $display("FAIL to_revoke st=%0d g=%h want 3/000", state, m_grants);
        end
        m_reqs = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_slave_busy();
        int e;
        slaves = 6'b001000; m_reqs = 12'h020;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (state !== 4'd0 || m_grants !== 12'h000) begin
                bad++; $display("FAIL busy_block st=%0d g=%h want 0/000", state, m_grants);
            end
        end
        slaves = '0;
        exp_q.push_back(5);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (state !== 4'd1 || m_grants !== oh(e) || mid_current !== 4'(e)) begin
            bad++;
            $display("FAIL busy_grant st=%0d g=%h mid=%0d want 1/%h/%0d",
                     state, m_grants, mid_current, oh(e), e);
        end
        bus_util = 1'b1; slaves = 6'b001000;
        repeat (2) @(negedge clk);
        total++;
        if (state !== 4'd2 || m_grants !== 12'h020) begin
            bad++; $display("FAIL busy_hold st=%0d g=%h want 2/020", state, m_grants);
        end
    endtask

    task automatic test_reset_active();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (state !== 4'd0 || m_grants !== 12'h000 || mid_current !== 4'hF) begin
            bad++;
            $display("FAIL rst_active st=%0d g=%h mid=%h want 0/000/f",
                     state, m_grants, mid_current);
        end
        rst = 1'b0; m_reqs = '0; bus_util = 1'b0; slaves = '0;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        int e;
        bit found;
`ifdef BUS_ROUND_ROBIN_EN
        exp_q.push_back(2); exp_q.push_back(5);
        exp_q.push_back(7); exp_q.push_back(2);
`else
        exp_q.push_back(2); exp_q.push_back(2);
        exp_q.push_back(2); exp_q.push_back(2);
`endif
        m_reqs = 12'h0A4;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (state == 4'd1) found = 1'b1;
            end
            total++;
            if (!found || mid_current !== 4'(e) || m_grants !== oh(e)) begin
                bad++;
                $display("FAIL rot_grant k=%0d mid=%0d g=%h want %0d/%h",
                         k, mid_current, m_grants, e, oh(e));
            end
            found = 1'b0;
            for (int c = 0; c < 25 && !found; c++) begin
                @(negedge clk);
                if (state == 4'd3) found = 1'b1;
            end
        end
        m_reqs = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_slave_busy();
        test_reset_active();
        test_rotation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
